// File: rtl/nmlo_pulse_responder_pkg.sv
// Shared definitions for the NMLO pulse responder: state encoding, default widths, timer sizing.
// The SETTLE encoding exists only when NMLO_SETTLE_EN is defined.
package nmlo_pulse_responder_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAMPLE   = 3'd1,
        ST_PULSE_HI = 3'd2,
        ST_PULSE_LO = 3'd3,
`ifdef NMLO_SETTLE_EN
        ST_SETTLE   = 3'd4,
`endif
        ST_DONE     = 3'd5
    } state_t;

    // Phase timer widens to 16 bits when a fixed phase length does not fit in cnt_w bits.
    function automatic int unsigned timer_width(int unsigned cnt_w, int unsigned sample_len,
                                                int unsigned settle_len);
        logic [63:0] limit;
        limit = 64'd1 << cnt_w;
        if ((64'(sample_len) >= limit) || (64'(settle_len) >= limit))
            return (cnt_w > 16) ? cnt_w : 16;
        return cnt_w;
    endfunction

endpackage

// File: rtl/nmlo_phase_timer.sv
// Loadable down-counter shared by every timed phase; last_c flags the final cycle of a phase.
module nmlo_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign last_c = (cnt == W'(1));

endmodule

// File: rtl/nmlo_pulse_responder.sv
// Trigger/idle responder driving the NMLO sample pin and a programmable integration pulse train.
// Optional post-train SETTLE phase enabled by defining NMLO_SETTLE_EN.
module nmlo_pulse_responder
    import nmlo_pulse_responder_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEFAULT,
    parameter int unsigned SAMPLE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [CNT_W-1:0] t_high,
    input  logic [CNT_W-1:0] t_low,
    output logic             idle,
    output logic             sample,
    output logic             pulse,
    output logic [CNT_W-1:0] pulse_count,
    output logic             done_pulse
);

    localparam int unsigned TW = timer_width(CNT_W, SAMPLE_CYCLES, SETTLE_CYCLES);

    state_t           state;
    state_t           state_nxt;
    logic             trigger_d;
    logic [CNT_W-1:0] np_q;
    logic [CNT_W-1:0] th_q;
    logic [CNT_W-1:0] tl_q;
    logic             start_c;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_last;

    assign start_c = (state == ST_IDLE) && trigger && !trigger_d;

    nmlo_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .last_c   (tmr_last)
    );

    // Next state and timer reload; the timer is reloaded on every timed state entry.
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            ST_IDLE: begin
                if (start_c) begin
                    state_nxt = ST_SAMPLE;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(SAMPLE_CYCLES);
                end
            end
            ST_SAMPLE: begin
                if (tmr_last) begin
                    if (np_q != '0) begin
                        state_nxt = ST_PULSE_HI;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(th_q);
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_PULSE_HI: begin
                if (tmr_last) begin
                    state_nxt = ST_PULSE_LO;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(tl_q);
                end
            end
            ST_PULSE_LO: begin
                if (tmr_last) begin
                    if (pulse_count < np_q) begin
                        state_nxt = ST_PULSE_HI;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(th_q);
                    end else begin
`ifdef NMLO_SETTLE_EN
                        state_nxt = ST_SETTLE;
                        tmr_load  = 1'b1;
                        tmr_val   = TW'(SETTLE_CYCLES);
`else
                        state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef NMLO_SETTLE_EN
            ST_SETTLE: begin
                if (tmr_last) begin
                    state_nxt = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, latched run parameters and outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            trigger_d   <= 1'b1;
            np_q        <= '0;
            th_q        <= CNT_W'(1);
            tl_q        <= CNT_W'(1);
            pulse_count <= '0;
            idle        <= 1'b1;
            sample      <= 1'b0;
            pulse       <= 1'b0;
            done_pulse  <= 1'b0;
        end else begin
            state     <= state_nxt;
            trigger_d <= trigger;
            if (start_c) begin
                np_q        <= num_pulses;
                th_q        <= (t_high == '0) ? CNT_W'(1) : t_high;
                tl_q        <= (t_low == '0) ? CNT_W'(1) : t_low;
                pulse_count <= '0;
            end else if ((state == ST_PULSE_HI) && tmr_last) begin
                pulse_count <= pulse_count + CNT_W'(1);
            end
            idle       <= (state_nxt == ST_IDLE);
            sample     <= (state_nxt == ST_SAMPLE);
            pulse      <= (state_nxt == ST_PULSE_HI);
            done_pulse <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_nmlo_pulse_responder.sv
// Self-checking bench for nmlo_pulse_responder against a per-cycle waveform model built from run parameters.
// Define NMLO_SETTLE_EN to check the settle build.
module tb_nmlo_pulse_responder;

    localparam int unsigned CNT_W         = 8;
    localparam int unsigned SAMPLE_CYCLES = 4;
    localparam int unsigned SETTLE_CYCLES = 16;
`ifdef NMLO_SETTLE_EN
    localparam int unsigned SETTLE_LEN = SETTLE_CYCLES;
`else
    localparam int unsigned SETTLE_LEN = 0;
`endif

    typedef struct packed {
        logic             idle;
        logic             sample;
        logic             pulse;
        logic             done_pulse;
        logic [CNT_W-1:0] count;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             trigger = 1'b1;
    logic [CNT_W-1:0] num_pulses = '0;
    logic [CNT_W-1:0] t_high = '0;
    logic [CNT_W-1:0] t_low = '0;
    logic             idle;
    logic             sample;
    logic             pulse;
    logic [CNT_W-1:0] pulse_count;
    logic             done_pulse;

    obs_t exp_q[$];
    obs_t obs_q[$];
    int   total = 0;
    int   bad = 0;

    nmlo_pulse_responder #(
        .CNT_W         (CNT_W),
        .SAMPLE_CYCLES (SAMPLE_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .num_pulses  (num_pulses),
        .t_high      (t_high),
        .t_low       (t_low),
        .idle        (idle),
        .sample      (sample),
        .pulse       (pulse),
        .pulse_count (pulse_count),
        .done_pulse  (done_pulse)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic i, logic s, logic p, logic d, int unsigned c);
        obs_t o;
        o.idle = i; o.sample = s; o.pulse = p; o.done_pulse = d; o.count = CNT_W'(c);
        return o;
    endfunction

    function automatic obs_t snap();
        return mk(idle, sample, pulse, done_pulse, int'(pulse_count));
    endfunction

    // Expected per-cycle pin levels from the trigger edge to two cycles past the return to idle.
    function automatic void build_exp(int unsigned np, int unsigned th, int unsigned tl);
        int unsigned hw = (th == 0) ? 1 : th;
        int unsigned lw = (tl == 0) ? 1 : tl;
        int unsigned pc = 0;
        exp_q.delete();
        repeat (SAMPLE_CYCLES) exp_q.push_back(mk(0, 1, 0, 0, pc));
        for (int unsigned p = 0; p < np; p++) begin
            repeat (hw) exp_q.push_back(mk(0, 0, 1, 0, pc));
            pc++;
            repeat (lw) exp_q.push_back(mk(0, 0, 0, 0, pc));
        end
        repeat (SETTLE_LEN) exp_q.push_back(mk(0, 0, 0, 0, pc));
        exp_q.push_back(mk(0, 0, 0, 1, pc));
        repeat (2) exp_q.push_back(mk(1, 0, 0, 0, pc));
    endfunction

    function automatic int unsigned busy_len(int unsigned np, int unsigned th, int unsigned tl);
        int unsigned hw = (th == 0) ? 1 : th;
        int unsigned lw = (tl == 0) ? 1 : tl;
        return SAMPLE_CYCLES + np * (hw + lw) + 1 + SETTLE_LEN;
    endfunction

    function automatic int unsigned obs_busy();
        int unsigned n = 0;
        foreach (obs_q[i]) if (!obs_q[i].idle) n++;
        return n;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++)
            if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Raise trigger and record one run; noisy mode scrambles inputs and trigger mid-run.
    task automatic do_run(int unsigned np, int unsigned th, int unsigned tl, bit noisy);
        @(negedge clk);
        num_pulses = CNT_W'(np);
        t_high     = CNT_W'(th);
        t_low      = CNT_W'(tl);
        trigger    = 1'b1;
        build_exp(np, th, tl);
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk);
            #1;
            obs_q.push_back(snap());
            if (noisy) begin
                num_pulses = CNT_W'($urandom);
                t_high     = CNT_W'($urandom);
                t_low      = CNT_W'($urandom);
                trigger    = (i + 4 < exp_q.size()) ? 1'($urandom) : 1'b1;
            end
        end
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic test_reset();
        int   m;
        int   starts;
        obs_t o;
        #12;
        o = snap();
        total++;
        if (o !== mk(1, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL reset_values got %h want %h", o, mk(1, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b0;
        starts = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (!idle) starts++;
        end
        total++;
        if (starts !== 0) begin
            bad++;
            $display("FAIL held_trigger_through_reset busy_cycles got %0d want 0", starts);
        end
        @(negedge clk);
        trigger = 1'b0;
        do_run(1, 1, 1, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL fresh_edge_run cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
    endtask

    task automatic test_basic();
        int m;
        do_run(3, 2, 3, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL basic_wave cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
        total++;
        if (obs_busy() !== 20 + SETTLE_LEN) begin
            bad++;
            $display("FAIL basic_busy got %0d want %0d", obs_busy(), 20 + SETTLE_LEN);
        end
        total++;
        if (pulse_count !== CNT_W'(3)) begin
            bad++;
            $display("FAIL basic_count got %0d want 3", pulse_count);
        end
    endtask

    task automatic test_zero_pulses();
        int m;
        do_run(0, 7, 7, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL zero_pulses_wave cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
        total++;
        if (obs_busy() !== 5 + SETTLE_LEN) begin
            bad++;
            $display("FAIL zero_pulses_busy got %0d want %0d", obs_busy(), 5 + SETTLE_LEN);
        end
    endtask

    task automatic test_zero_widths();
        int m;
        do_run(2, 0, 0, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL zero_widths_wave cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
        total++;
        if (obs_busy() !== 9 + SETTLE_LEN) begin
            bad++;
            $display("FAIL zero_widths_busy got %0d want %0d", obs_busy(), 9 + SETTLE_LEN);
        end
    endtask

    task automatic test_reset_mid_run();
        int   m;
        obs_t o;
        @(negedge clk);
        num_pulses = CNT_W'(5);
        t_high     = CNT_W'(4);
        t_low      = CNT_W'(4);
        trigger    = 1'b1;
        repeat (SAMPLE_CYCLES + 10) @(posedge clk);
        #1;
        total++;
        if (pulse !== 1'b1 || pulse_count !== CNT_W'(1)) begin
            bad++;
            $display("FAIL mid_run_second_pulse got pulse=%b count=%0d want pulse=1 count=1", pulse, pulse_count);
        end
        #2;
        rst = 1'b1;
        #1;
        o = snap();
        total++;
        if (o !== mk(1, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL async_reset_values got %h want %h", o, mk(1, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst     = 1'b0;
        trigger = 1'b0;
        do_run(2, 1, 2, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL post_reset_run cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
    endtask

    task automatic test_random();
        int          m;
        int unsigned np, th, tl;
        for (int r = 0; r < 8; r++) begin
            np = $urandom_range(0, 6);
            th = $urandom_range(0, 4);
            tl = $urandom_range(0, 4);
            do_run(np, th, tl, 1'b1);
            m = first_diff();
            total++;
            if (m >= 0) begin
                bad++;
                $display("FAIL random_run%0d np=%0d th=%0d tl=%0d cyc %0d got %h want %h",
                         r, np, th, tl, m, obs_q[m], exp_q[m]);
            end
            total++;
            if (obs_busy() !== busy_len(np, th, tl)) begin
                bad++;
                $display("FAIL random_busy%0d got %0d want %0d", r, obs_busy(), busy_len(np, th, tl));
            end
        end
    endtask

    task automatic test_max_pulses();
        int m;
        do_run(255, 0, 0, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL max_pulses_wave cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
        total++;
        if (pulse_count !== CNT_W'(255)) begin
            bad++;
            $display("FAIL max_pulses_count got %0d want 255", pulse_count);
        end
    endtask

    task automatic test_back_to_back();
        int m;
        do_run(1, 3, 1, 1'b0);
        do_run(2, 2, 1, 1'b0);
        m = first_diff();
        total++;
        if (m >= 0) begin
            bad++;
            $display("FAIL back_to_back_wave cyc %0d got %h want %h", m, obs_q[m], exp_q[m]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_pulses();
        test_zero_widths();
        test_reset_mid_run();
        test_random();
        test_max_pulses();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
